data_path_param: RTL and testbench

//   Parametrised K&S datapath that succeeds the fixed 16-bit datapath.

---
 rtl/data_path_param.sv | 161 ++++++++++++++++
 tb/tb_data_path_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path_param.sv
// Parametrised K&S datapath: instruction register, decoder, program counter,
// register file, eight-op ALU and flags register between the control unit and RAM.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
  } decoded_instruction_type;
endpackage

module data_path_param
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [2:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [ADDR_W-1:0]       pc_out,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int MSB    = DATA_W - 1;

  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [7:0]        opcode;
  logic [REG_AW-1:0] ra, rb, rc;
  logic [ADDR_W-1:0] addr;

  assign opcode = ir[DATA_W-1 -: 8];

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    decoded_instruction = I_NOP;
    ra   = '0;
    rb   = '0;
    rc   = '0;
    addr = '0;
    case (opcode)
      8'h81: begin decoded_instruction = I_LOAD;  rc = ir[ADDR_W +: REG_AW]; addr = ir[ADDR_W-1:0]; end
      8'h82: begin decoded_instruction = I_STORE; ra = ir[ADDR_W +: REG_AW]; addr = ir[ADDR_W-1:0]; end
      8'h91: begin
        decoded_instruction = I_MOVE;
        ra = ir[REG_AW-1:0];
        rb = ir[REG_AW-1:0];
        rc = ir[2*REG_AW +: REG_AW];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        case (opcode[2:0])
          3'd1:    decoded_instruction = I_ADD;
          3'd2:    decoded_instruction = I_SUB;
          3'd3:    decoded_instruction = I_AND;
          default: decoded_instruction = I_OR;
        endcase
        ra = ir[REG_AW-1:0];
        rb = ir[REG_AW +: REG_AW];
        rc = ir[2*REG_AW +: REG_AW];
      end
      8'h01: begin decoded_instruction = I_BRANCH; addr = ir[ADDR_W-1:0]; end
      8'h02: begin decoded_instruction = I_BZERO;  addr = ir[ADDR_W-1:0]; end
      8'h03: begin decoded_instruction = I_BNEG;   addr = ir[ADDR_W-1:0]; end
      8'h05: begin decoded_instruction = I_BOV;    addr = ir[ADDR_W-1:0]; end
      8'h06: begin decoded_instruction = I_BNOV;   addr = ir[ADDR_W-1:0]; end
      8'h0A: begin decoded_instruction = I_BNNEG;  addr = ir[ADDR_W-1:0]; end
      8'h0B: begin decoded_instruction = I_BNZERO; addr = ir[ADDR_W-1:0]; end
      8'hFF: decoded_instruction = I_HALT;
      default: ;
    endcase
  end

  logic [DATA_W-1:0] a, b, alu_res, bus_c;
  logic [DATA_W:0]   sum;
  logic              alu_uov, alu_sov;

  assign a = rf[ra];
  assign b = rf[rb];

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    case (operation)
      3'b000: alu_res = a | b;
      3'b001: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[MSB:0];
        alu_uov = sum[DATA_W];
        // carry into the MSB is recovered from the MSB sum bit
        alu_sov = (a[MSB] ^ b[MSB] ^ alu_res[MSB]) ^ sum[DATA_W];
      end
      3'b010: begin
        sum     = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum[MSB:0];
        alu_uov = ~sum[DATA_W];
        alu_sov = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      3'b011: alu_res = a & b;
      3'b100: alu_res = a ^ b;
      3'b101: begin alu_res = {a[MSB-1:0], 1'b0}; alu_uov = a[MSB]; end
      3'b110: begin alu_res = {1'b0, a[MSB:1]};   alu_uov = a[0];   end
      default: alu_res = a;
    endcase
  end

  assign bus_c    = c_sel ? alu_res : data_in;
  assign ram_addr = addr_sel ? addr : pc;
  assign pc_out   = pc;
  assign data_out = a;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge IR/PC; a write in the same cycle as ir_enable
  // therefore lands in the old instruction's rc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir                <= '0;
      pc                <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else begin
      if (ir_enable) ir <= data_in;
      if (pc_enable) pc <= branch ? addr : pc + ADDR_W'(1);
      if (flags_reg_enable) begin
        zero_op           <= (alu_res == '0);
        neg_op            <= alu_res[MSB];
        unsigned_overflow <= alu_uov;
        signed_overflow   <= alu_sov;
      end
    end
  end

  // NOTE: the register file is built from flops, so it is cleared by the
  // async reset like the rest of the state (a RAM macro could not be).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (write_reg_enable) begin
      rf[rc] <= bus_c;
    end
  end
endmodule

// File: tb/tb_data_path_param.sv
// Bench for data_path_param: a 16-bit/4-reg and a 32-bit/8-reg instance share
// control inputs and are checked against a behavioural model of the datapath.
module tb_data_path_param;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic       write_reg_enable, flags_reg_enable;
  logic [2:0] operation;
  logic [15:0] din_a;
  logic [31:0] din_b;

  decoded_instruction_type dec_a, dec_b;
  logic z_a, n_a, u_a, s_a, z_b, n_b, u_b, s_b;
  logic [4:0]  ram_addr_a, pc_a, ram_addr_b, pc_b;
  logic [15:0] dout_a;
  logic [31:0] dout_b;

  data_path_param #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .decoded_instruction(dec_a), .zero_op(z_a), .neg_op(n_a),
    .unsigned_overflow(u_a), .signed_overflow(s_a), .ram_addr(ram_addr_a),
    .pc_out(pc_a), .data_out(dout_a), .data_in(din_a));

  data_path_param #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .decoded_instruction(dec_b), .zero_op(z_b), .neg_op(n_b),
    .unsigned_overflow(u_b), .signed_overflow(s_b), .ram_addr(ram_addr_b),
    .pc_out(pc_b), .data_out(dout_b), .data_in(din_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int AW = 5;
  int DW [2]  = '{16, 32};
  int RAW [2] = '{2, 3};

  longint unsigned m_ir [2];
  longint unsigned m_pc [2];
  longint unsigned m_rf [2][8];
  bit m_z [2], m_n [2], m_u [2], m_s [2];

  typedef struct {
    int              dec;
    int              ra, rb, rc;
    longint unsigned addr;
  } dec_t;

  function automatic dec_t m_decode(int k);
    dec_t d;
    longint unsigned ir = m_ir[k];
    longint unsigned rm = (64'd1 << RAW[k]) - 1;
    int opc = int'((ir >> (DW[k] - 8)) & 64'hFF);
    int f0 = int'(ir & rm);
    int f1 = int'((ir >> RAW[k]) & rm);
    int f2 = int'((ir >> (2 * RAW[k])) & rm);
    int fm = int'((ir >> AW) & rm);
    longint unsigned fa = ir & 64'h1F;
    d = '{int'(I_NOP), 0, 0, 0, 64'd0};
    case (opc)
      'h81: begin d.dec = int'(I_LOAD);  d.rc = fm; d.addr = fa; end
      'h82: begin d.dec = int'(I_STORE); d.ra = fm; d.addr = fa; end
      'h91: begin d.dec = int'(I_MOVE);  d.ra = f0; d.rb = f0; d.rc = f2; end
      'hA1: begin d.dec = int'(I_ADD);   d.ra = f0; d.rb = f1; d.rc = f2; end
      'hA2: begin d.dec = int'(I_SUB);   d.ra = f0; d.rb = f1; d.rc = f2; end
      'hA3: begin d.dec = int'(I_AND);   d.ra = f0; d.rb = f1; d.rc = f2; end
      'hA4: begin d.dec = int'(I_OR);    d.ra = f0; d.rb = f1; d.rc = f2; end
      'h01: begin d.dec = int'(I_BRANCH); d.addr = fa; end
      'h02: begin d.dec = int'(I_BZERO);  d.addr = fa; end
      'h03: begin d.dec = int'(I_BNEG);   d.addr = fa; end
      'h05: begin d.dec = int'(I_BOV);    d.addr = fa; end
      'h06: begin d.dec = int'(I_BNOV);   d.addr = fa; end
      'h0A: begin d.dec = int'(I_BNNEG);  d.addr = fa; end
      'h0B: begin d.dec = int'(I_BNZERO); d.addr = fa; end
      'hFF: d.dec = int'(I_HALT);
      default: ;
    endcase
    return d;
  endfunction

  // ALU flags derived from full-precision signed/unsigned arithmetic
  function automatic void m_alu(input int k, input int op, input longint unsigned a,
                                input longint unsigned b, output longint unsigned res,
                                output bit z, output bit n, output bit u, output bit s);
    int w = DW[k];
    longint unsigned mask = (64'd1 << w) - 1;
    longint half = longint'(64'd1 << (w - 1));
    longint sa = (a >= 64'(half)) ? longint'(a) - 2 * half : longint'(a);
    longint sb = (b >= 64'(half)) ? longint'(b) - 2 * half : longint'(b);
    u = 1'b0;
    s = 1'b0;
    case (op)
      0: res = a | b;
      1: begin res = (a + b) & mask; u = (a + b) > mask; s = (sa + sb >= half) || (sa + sb < -half); end
      2: begin res = (a - b) & mask; u = a < b;          s = (sa - sb >= half) || (sa - sb < -half); end
      3: res = a & b;
      4: res = a ^ b;
      5: begin res = (a << 1) & mask; u = bit'((a >> (w - 1)) & 1); end
      6: begin res = a >> 1;          u = bit'(a & 1); end
      default: res = a;
    endcase
    z = (res == 0);
    n = bit'((res >> (w - 1)) & 1);
  endfunction

  function automatic longint unsigned din_of(int k);
    return (k == 0) ? longint'(din_a) : longint'(din_b);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_ir[k] = 0; m_pc[k] = 0;
      m_z[k] = 0; m_n[k] = 0; m_u[k] = 0; m_s[k] = 0;
      for (int r = 0; r < 8; r++) m_rf[k][r] = 0;
    end
  endtask

  task automatic m_edge();
    for (int k = 0; k < 2; k++) begin
      dec_t d = m_decode(k);
      longint unsigned res;
      bit z, n, u, s;
      m_alu(k, int'(operation), m_rf[k][d.ra], m_rf[k][d.rb], res, z, n, u, s);
      if (write_reg_enable) m_rf[k][d.rc] = c_sel ? res : din_of(k);
      if (flags_reg_enable) begin m_z[k] = z; m_n[k] = n; m_u[k] = u; m_s[k] = s; end
      if (pc_enable) m_pc[k] = branch ? d.addr : (m_pc[k] + 1) % 32;
      if (ir_enable) m_ir[k] = din_of(k);
    end
  endtask

  task automatic compare_all();
    dec_t da = m_decode(0);
    dec_t db = m_decode(1);
    check("A.dec",  int'(dec_a), da.dec);
    check("A.pc",   pc_a, m_pc[0]);
    check("A.ram",  ram_addr_a, addr_sel ? da.addr : m_pc[0]);
    check("A.dout", dout_a, m_rf[0][da.ra]);
    check("A.flags", {z_a, n_a, u_a, s_a}, {m_z[0], m_n[0], m_u[0], m_s[0]});
    check("B.dec",  int'(dec_b), db.dec);
    check("B.pc",   pc_b, m_pc[1]);
    check("B.ram",  ram_addr_b, addr_sel ? db.addr : m_pc[1]);
    check("B.dout", dout_b, m_rf[1][db.ra]);
    check("B.flags", {z_b, n_b, u_b, s_b}, {m_z[1], m_n[1], m_u[1], m_s[1]});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit pe, input bit br, input bit ie, input bit as, input bit cs,
                      input bit we, input bit fe, input bit [2:0] op,
                      input logic [15:0] da, input logic [31:0] db);
    pc_enable = pe; branch = br; ir_enable = ie; addr_sel = as; c_sel = cs;
    write_reg_enable = we; flags_reg_enable = fe; operation = op;
    din_a = da; din_b = db;
    #1 compare_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic ld_ir(input logic [15:0] da, input logic [31:0] db);
    step(0, 0, 1, 0, 0, 0, 0, 3'd0, da, db);
  endtask

  task automatic wr(input bit cs, input bit [2:0] op, input bit fe,
                    input logic [15:0] da, input logic [31:0] db);
    step(0, 0, 0, 0, cs, 1, fe, op, da, db);
  endtask

  function automatic longint unsigned rand_word(int k);
    bit [7:0] ops [15] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                           8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'hFF};
    longint unsigned mask = (64'd1 << DW[k]) - 1;
    longint unsigned w = {$urandom, $urandom} & mask;
    longint unsigned opc = ($urandom_range(3) != 0) ? longint'(ops[$urandom_range(14)])
                                                    : longint'($urandom_range(255));
    // occasional extreme operands exercise the overflow flags
    case ($urandom_range(5))
      0: return mask;
      1: return mask >> 1;
      2: return 64'd1 << (DW[k] - 1);
      default: ;
    endcase
    if ($urandom_range(1) == 0) return w;
    return (w & ~(64'hFF << (DW[k] - 8))) | (opc << (DW[k] - 8));
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    {branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable} = '0;
    operation = 3'd0; din_a = '0; din_b = '0;
    m_reset();

    // reset state
    #12;
    check("rst.pc",    pc_a, 0);
    check("rst.ram",   ram_addr_a, 0);
    check("rst.flags", {z_a, n_a, u_a, s_a}, 0);
    check("rst.dec",   int'(dec_a), int'(I_NOP));
    check("rst.dout",  dout_a, 0);
    check("rst.doutB", dout_b, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // LOAD r1 then STORE r1
    ld_ir(16'h8125, 32'h0);
    wr(0, 3'd0, 0, 16'h1234, 32'h0);
    ld_ir(16'h8225, 32'h0);
    addr_sel = 1'b1;
    #1;
    check("store.dout", dout_a, 16'h1234);
    check("store.ram",  ram_addr_a, 5);

    // ADD 0x7FFF + 1, then SUB 0 - 1
    ld_ir(16'h8100, 32'h0);  wr(0, 3'd0, 0, 16'h7FFF, 32'h0);
    ld_ir(16'h8120, 32'h0);  wr(0, 3'd0, 0, 16'h0001, 32'h0);
    ld_ir(16'hA124, 32'h0);  wr(1, 3'd1, 1, 16'h0, 32'h0);
    check("add.flags", {z_a, n_a, u_a, s_a}, 4'b0101);
    ld_ir(16'h8160, 32'h0);  wr(0, 3'd0, 0, 16'h0000, 32'h0);
    ld_ir(16'hA227, 32'h0);  wr(1, 3'd2, 1, 16'h0, 32'h0);
    check("sub.flags", {z_a, n_a, u_a, s_a}, 4'b0110);

    // reset between edges while a write is pending: r0 (0x7FFF) reads 0 at once
    ld_ir(16'h8200, 32'h0);
    addr_sel = 1'b0; write_reg_enable = 1'b1; din_a = 16'hBEEF;
    #1;
    check("pre.dout", dout_a, 16'h7FFF);
    #1 rst_n = 1'b0;
    #1;
    m_reset();
    check("midrst.dout", dout_a, 0);
    check("midrst.dec",  int'(dec_a), int'(I_NOP));
    @(posedge clk) #1;
    check("midrst.hold", dout_a, 0);
    @(negedge clk) rst_n = 1'b1;
    write_reg_enable = 1'b0;
    @(posedge clk) #1;

    // PC wrap and branch
    for (int i = 0; i < 31; i++) step(1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);
    check("pc.31", pc_a, 31);
    step(1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);
    check("pc.wrap", pc_a, 0);
    ld_ir(16'h0107, 32'h0100_0007);
    step(1, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);
    check("pc.branch", pc_a, 7);
    check("pc.branchB", pc_b, 7);

    // 32-bit instance: XOR r7 <- r5 ^ r6, SHR of 1
    ld_ir(16'h0, 32'h8100_00A0);  wr(0, 3'd0, 0, 16'h0, 32'hFFFF_0000);
    ld_ir(16'h0, 32'h8100_00C0);  wr(0, 3'd0, 0, 16'h0, 32'h0F0F_0F0F);
    ld_ir(16'h0, 32'hA100_01F5);  wr(1, 3'd4, 1, 16'h0, 32'h0);
    check("xor.neg", n_b, 1);
    ld_ir(16'h0, 32'h8200_00E0);
    check("xor.r7", dout_b, 32'hF0F0_0F0F);
    ld_ir(16'h0, 32'h8100_0020);  wr(0, 3'd0, 0, 16'h0, 32'h1);
    ld_ir(16'h0, 32'hA100_0081);  wr(1, 3'd6, 1, 16'h0, 32'h0);
    check("shr.zero", z_b, 1);
    check("shr.uov",  u_b, 1);

    // unknown opcode: NOP with all fields zero
    ld_ir(16'h7E37, 32'h7E00_1234);
    addr_sel = 1'b1;
    #1;
    check("unk.dec", int'(dec_a), int'(I_NOP));
    check("unk.ram", ram_addr_a, 0);

    // randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)),
           bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)),
           bit'($urandom_range(1)), 3'($urandom_range(7)),
           16'(rand_word(0)), 32'(rand_word(1)));
    end
    #1 compare_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
